// File: rtl/mips_dmem_pkg.sv
// mips_dmem_pkg: shared constants and types for the MIPS data-memory/MMIO responder
package mips_dmem_pkg;
    localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
    localparam logic [3:0]  OFF_LED     = 4'h0;
    localparam logic [3:0]  OFF_CYCLE   = 4'h4;
    localparam logic [3:0]  OFF_TCMP    = 4'h8;
    localparam logic [3:0]  OFF_TSTAT   = 4'hC;
    localparam int          TS_EXP      = 0;
    localparam int          TS_IE       = 1;
    localparam int          TS_FAULT    = 2;
    localparam logic [31:0] FAULT_RDATA = 32'hDEAD_BEEF;
    typedef enum logic {RGN_RAM, RGN_MMIO} region_e;
endpackage

// File: rtl/mips_cmp_timer.sv
// mips_cmp_timer: compare timer, TSTAT flags and registered irq; `MIPS_DMEM_ALIGN_CHK_EN adds the sticky fault bit
module mips_cmp_timer
    import mips_dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tcmp_we,
    input  logic        tstat_we,
    input  logic [31:0] wdata,
`ifdef MIPS_DMEM_ALIGN_CHK_EN
    input  logic        fault_set,
`endif
    output logic [31:0] tcmp,
    output logic [31:0] tstat,
    output logic        irq
);
    logic [31:0] timer_q, timer_d, tcmp_q, tcmp_d;
    logic        expired_q, expired_d, ie_q, ie_d, irq_q, irq_d, hit;
`ifdef MIPS_DMEM_ALIGN_CHK_EN
    logic        fault_q, fault_d;
`endif
    always_comb begin
        hit       = tcmp_q != '0 && timer_q == tcmp_q && !tcmp_we;
        tcmp_d    = tcmp_we ? wdata : tcmp_q;
        timer_d   = (tcmp_we || hit || tcmp_q == '0) ? '0 : timer_q + 32'd1;
        expired_d = hit | (expired_q & ~(tstat_we & wdata[TS_EXP]));
        ie_d      = tstat_we ? wdata[TS_IE] : ie_q;
        irq_d     = expired_q & ie_q;
        tstat     = '0;
        tstat[TS_EXP] = expired_q;
        tstat[TS_IE]  = ie_q;
`ifdef MIPS_DMEM_ALIGN_CHK_EN
        fault_d   = fault_set | (fault_q & ~(tstat_we & wdata[TS_FAULT]));
        tstat[TS_FAULT] = fault_q;
`endif
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= '0;
            tcmp_q    <= '0;
            expired_q <= 1'b0;
            ie_q      <= 1'b0;
            irq_q     <= 1'b0;
`ifdef MIPS_DMEM_ALIGN_CHK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            timer_q   <= timer_d;
            tcmp_q    <= tcmp_d;
            expired_q <= expired_d;
            ie_q      <= ie_d;
            irq_q     <= irq_d;
`ifdef MIPS_DMEM_ALIGN_CHK_EN
            fault_q   <= fault_d;
`endif
        end
    end
    assign tcmp = tcmp_q;
    assign irq  = irq_q;
endmodule

// File: rtl/mips_dmem_mmio.sv
// mips_dmem_mmio: word RAM plus LED/CYCLE/timer MMIO for the MIPS load/store port; `MIPS_DMEM_ALIGN_CHK_EN enables alignment faults
module mips_dmem_mmio
    import mips_dmem_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int LED_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      addr,
    input  logic             memwrite,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [LED_W-1:0] leds,
    output logic             irq
);
    localparam int AW = $clog2(RAM_WORDS);
    logic [31:0]      mem [RAM_WORDS];
    logic [AW-1:0]    idx;
    region_e          rgn;
    logic             mmio_hit, wr_ok, ram_we, tcmp_we, tstat_we;
    logic [3:0]       off;
    logic [31:0]      cycle_q, cycle_d, mmio_rd, rd, tcmp, tstat;
    logic [LED_W-1:0] led_q, led_d;
    always_comb begin
        rgn      = (addr & MMIO_BASE) != '0 ? RGN_MMIO : RGN_RAM;
        idx      = addr[AW+1:2];
        off      = {addr[3:2], 2'b00};
        mmio_hit = rgn == RGN_MMIO && addr[30:4] == '0;
`ifdef MIPS_DMEM_ALIGN_CHK_EN
        wr_ok    = memwrite && addr[1:0] == 2'b00;
`else
        wr_ok    = memwrite;
`endif
        ram_we   = wr_ok && rgn == RGN_RAM;
        tcmp_we  = wr_ok && mmio_hit && off == OFF_TCMP;
        tstat_we = wr_ok && mmio_hit && off == OFF_TSTAT;
        led_d    = (wr_ok && mmio_hit && off == OFF_LED) ? writedata[LED_W-1:0] : led_q;
        cycle_d  = cycle_q + 32'd1;
        mmio_rd  = off == OFF_LED   ? 32'(led_q) :
                   off == OFF_CYCLE ? cycle_q    :
                   off == OFF_TCMP  ? tcmp       : tstat;
        rd       = rgn == RGN_RAM ? mem[idx] : mmio_hit ? mmio_rd : '0;
`ifdef MIPS_DMEM_ALIGN_CHK_EN
        readdata = addr[1:0] != 2'b00 ? FAULT_RDATA : rd;
`else
        readdata = rd;
`endif
    end
`ifndef MIPS_DMEM_ALIGN_CHK_EN
    logic unused_lsb;
    assign unused_lsb = ^addr[1:0];
`endif
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[idx] <= writedata;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q   <= '0;
            cycle_q <= '0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
        end
    end
    assign leds = led_q;
    mips_cmp_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .tcmp_we  (tcmp_we),
        .tstat_we (tstat_we),
        .wdata    (writedata),
`ifdef MIPS_DMEM_ALIGN_CHK_EN
        .fault_set(memwrite && addr[1:0] != 2'b00),
`endif
        .tcmp     (tcmp),
        .tstat    (tstat),
        .irq      (irq)
    );
endmodule

// File: tb/tb_mips_dmem_mmio.sv
// tb_mips_dmem_mmio: scoreboard bench for RAM, LED, CYCLE, compare timer, async reset and alignment faults
module tb_mips_dmem_mmio;
    localparam logic [31:0] A_LED   = 32'h8000_0000;
    localparam logic [31:0] A_CYCLE = 32'h8000_0004;
    localparam logic [31:0] A_TCMP  = 32'h8000_0008;
    localparam logic [31:0] A_TSTAT = 32'h8000_000C;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0;
    logic        memwrite = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic        irq;
    logic [31:0] ref_cyc;
    logic [31:0] c0;
    logic [31:0] expq [$];
    int          checks = 0;
    int          errors = 0;

    mips_dmem_mmio #(.RAM_WORDS(64), .LED_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .addr     (addr),
        .memwrite (memwrite),
        .writedata(writedata),
        .readdata (readdata),
        .leds     (leds),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) ref_cyc <= '0;
        else          ref_cyc <= ref_cyc + 32'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // called at a negedge; the store commits on the following posedge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        writedata = d;
        memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        memwrite = 1'b0;
        expq.push_back(exp);
        #1;
        chk(tag, readdata, expq.pop_front());
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_cyc(2);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        ld("rst_cycle", A_CYCLE, 32'h0);
        ld("rst_tcmp", A_TCMP, 32'h0);
        ld("rst_tstat", A_TSTAT, 32'h0);
        ld("rst_led_rd", A_LED, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        wr(32'h0000_0010, 32'h1234_5678);
        ld("ram_rd", 32'h0000_0010, 32'h1234_5678);
        ld("ram_alias", 32'h0000_0110, 32'h1234_5678);
        wr(32'h0000_01FC, 32'hA5A5_0F0F);
        ld("ram_top", 32'h0000_00FC, 32'hA5A5_0F0F);
        ld("ram_keep", 32'h0000_0010, 32'h1234_5678);

        wr(A_LED, 32'h0000_0123);
        chk("led_trunc", 32'(leds), 32'h23);
        ld("led_rd_trunc", A_LED, 32'h23);
        wr(A_LED, 32'h0000_00FF);
        chk("led_ff", 32'(leds), 32'hFF);
        ld("led_rd_ff", A_LED, 32'hFF);
        wr(32'h8000_0010, 32'h55);
        chk("unmapped_wr", 32'(leds), 32'hFF);
        ld("unmapped_rd", 32'h8000_0010, 32'h0);
        ld("cycle_a", A_CYCLE, ref_cyc);
        c0 = ref_cyc;
        wait_cyc(5);
        ld("cycle_diff5", A_CYCLE, c0 + 32'd5);
        wr(A_CYCLE, 32'h0);
        ld("cycle_ro", A_CYCLE, ref_cyc);

        wr(A_TSTAT, 32'h2);
        wr(A_TCMP, 32'd3);
        ld("tcmp_rd", A_TCMP, 32'd3);
        ld("t_n0", A_TSTAT, 32'h2);
        wait_cyc(3);
        ld("t_n3", A_TSTAT, 32'h2);
        chk("irq_n3", 32'(irq), 32'h0);
        wait_cyc(1);
        ld("t_exp", A_TSTAT, 32'h3);
        chk("irq_n4", 32'(irq), 32'h0);
        wait_cyc(1);
        chk("irq_n5", 32'(irq), 32'h1);
        wr(A_TSTAT, 32'h3);
        ld("t_w1c", A_TSTAT, 32'h2);
        chk("irq_hold", 32'(irq), 32'h1);
        wait_cyc(1);
        chk("irq_drop", 32'(irq), 32'h0);
        wr(A_TSTAT, 32'h3);
        ld("set_wins", A_TSTAT, 32'h3);
        wr(A_TSTAT, 32'h3);
        ld("clr_again", A_TSTAT, 32'h2);
        wait_cyc(2);
        wr(A_TCMP, 32'd3);
        ld("tcmp_wins", A_TSTAT, 32'h2);
        wait_cyc(3);
        ld("restart_n3", A_TSTAT, 32'h2);
        wait_cyc(1);
        ld("restart_exp", A_TSTAT, 32'h3);
        wait_cyc(1);
        chk("irq_pre_rst", 32'(irq), 32'h1);
        chk("leds_pre_rst", 32'(leds), 32'hFF);

        #2 reset_n = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_leds", 32'(leds), 32'h0);
        ld("arst_cycle", A_CYCLE, 32'h0);
        ld("arst_tstat", A_TSTAT, 32'h0);
        ld("arst_tcmp", A_TCMP, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(3);
        ld("ram_survives", 32'h0000_0010, 32'h1234_5678);
        ld("cycle_post", A_CYCLE, ref_cyc);
        ld("halted_tstat", A_TSTAT, 32'h0);

`ifdef MIPS_DMEM_ALIGN_CHK_EN
        wr(32'h0000_0012, 32'hCAFE_0001);
        ld("mis_ram_keep", 32'h0000_0010, 32'h1234_5678);
        ld("mis_fault", A_TSTAT, 32'h4);
        ld("mis_rd", 32'h0000_0012, 32'hDEAD_BEEF);
        wr(A_TSTAT, 32'h4);
        ld("fault_w1c", A_TSTAT, 32'h0);
`else
        wr(32'h0000_0012, 32'hCAFE_0001);
        ld("mis_ram_wr", 32'h0000_0010, 32'hCAFE_0001);
        ld("mis_rd", 32'h0000_0012, 32'hCAFE_0001);
        ld("no_fault", A_TSTAT, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
